// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, derived totals, sync windows
// and the RGB332 field layout used by the timing generator and the renderer.
package vga_timing_gen_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_PIX_DIV   = 2;
    localparam bit DEF_SYNC_POL  = 1'b0;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    localparam int CNT_W = 10;

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication keeps full-scale codes at full scale (111 -> FF, 00 -> 00).
    function automatic rgb888_t expand_rgb332(input logic [7:0] c);
        rgb888_t o;
        o.r = {c[R_HI:R_LO], c[R_HI:R_LO], c[R_HI:R_HI-1]};
        o.g = {c[G_HI:G_LO], c[G_HI:G_LO], c[G_HI:G_HI-1]};
        o.b = {4{c[B_HI:B_LO]}};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_div.sv
// Pixel-rate divider: pix_en strobes on the last system clock of each pixel and
// vga_clk is a registered half-period square wave rising mid-pixel.
module vga_timing_gen_pix_div #(
    parameter int PIX_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int               DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             vga_clk_q;

    assign pix_en_o = (div_q == DIV_MAX);

    always_comb begin
        div_d = pix_en_o ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= (div_d >= DIV_HALF);
        end
    end

    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel request counters, sync decode and a one-pixel
// registered output stage feeding the video DAC.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int PIX_DIV   = DEF_PIX_DIV,
    parameter bit SYNC_POL  = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] next_x,
    output logic [CNT_W-1:0] next_y,
    input  logic [7:0]       color_in,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_clk,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_FIN = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_FIN = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             active;
    rgb888_t          rgb_d, rgb_q;
    logic             hs_d, hs_q;
    logic             vs_d, vs_q;
    logic             blank_n_q;
    logic             frame_start_q;

    vga_timing_gen_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk_i     (clk),
        .rst_i     (rst),
        .pix_en_o  (pix_en),
        .vga_clk_o (vga_clk)
    );

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decode from the pre-increment counters so outputs trail next_x by one pixel.
    always_comb begin
        active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        rgb_d  = active ? expand_rgb332(color_in) : '0;
        hs_d   = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_FIN)) ? SYNC_POL : ~SYNC_POL;
        vs_d   = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_FIN)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
            if (pix_en) begin
                rgb_q     <= rgb_d;
                blank_n_q <= active;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
            end
        end
    end

    assign next_x      = h_cnt_q;
    assign next_y      = v_cnt_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal geometry, shortened vertical geometry so
// whole frames fit in a short run; outputs compared every clock to a time-based model.
module tb_vga_timing_gen;

    localparam int HT = 800;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = VV + VF + VS + VB;
    localparam int PD = 2;
    localparam longint FRAME_CLKS = longint'(HT) * VT * PD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] color_in;
    logic [9:0] next_x, next_y;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start;

    int         mode = 0;
    logic [7:0] lut [256];
    longint     kc = 0;
    int         total = 0;
    int         bad = 0;

    vga_timing_gen #(
        .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_VISIBLE (VV),  .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .PIX_DIV   (PD),  .SYNC_POL (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .next_x (next_x), .next_y (next_y),
        .color_in (color_in), .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
        .vga_hs (vga_hs), .vga_vs (vga_vs), .vga_blank_n (vga_blank_n),
        .vga_clk (vga_clk), .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    // Clocks elapsed since the last clock edge that saw reset.
    always @(posedge clk) begin
        if (rst) kc <= 0;
        else     kc <= kc + 1;
    end

    function automatic logic [7:0] render(input logic [9:0] x, input logic [9:0] y, input int md);
        logic [7:0] idx;
        idx = 8'((int'(x) * 3 + int'(y) * 7) % 256);
        case (md)
            0:       return lut[idx];
            1:       return (x == 10'd100) ? 8'hE3 : 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        color_in = render(next_x, next_y, mode);
    end

    function automatic logic [48:0] snap();
        return {next_x, next_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start};
    endfunction

    // Expected outputs after k clocks from reset: pixel index = clocks / PD,
    // outputs show the pixel requested one pixel period earlier.
    function automatic logic [48:0] model_out(input longint k, input int md);
        longint n, m;
        int cx, cy, h, v;
        logic [7:0] c, r, g, b;
        logic act, hs, vs, fs, vc, bl;
        n  = k / PD;
        cx = int'(n % HT);
        cy = int'((n / HT) % VT);
        vc = (k % PD) >= (PD / 2);
        if (k < PD) begin
            r = 0; g = 0; b = 0; bl = 0; hs = 1; vs = 1; fs = 0;
        end else begin
            m   = n - 1;
            h   = int'(m % HT);
            v   = int'((m / HT) % VT);
            act = (h < 640) && (v < VV);
            c   = render(10'(h), 10'(v), md);
            r   = act ? {c[7:5], c[7:5], c[7:6]} : 8'h00;
            g   = act ? {c[4:2], c[4:2], c[4:3]} : 8'h00;
            b   = act ? {c[1:0], c[1:0], c[1:0], c[1:0]} : 8'h00;
            bl  = act;
            hs  = !((h >= 656) && (h < 752));
            vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            fs  = ((k % PD) == 0) && ((m % (longint'(HT) * VT)) == 0);
        end
        return {10'(cx), 10'(cy), r, g, b, hs, vs, bl, vc, fs};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total += 6;
        if (next_x !== 10'd0)   begin bad++; $display("FAIL rst_x got=%0d exp=0", next_x); end
        if (next_y !== 10'd0)   begin bad++; $display("FAIL rst_y got=%0d exp=0", next_y); end
        if ({vga_hs, vga_vs} !== 2'b11) begin bad++; $display("FAIL rst_sync got=%b exp=11", {vga_hs, vga_vs}); end
        if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL rst_blank got=%b exp=0", vga_blank_n); end
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin bad++; $display("FAIL rst_rgb got=%h exp=0", {vga_r, vga_g, vga_b}); end
        if ({frame_start, vga_clk} !== 2'b00) begin bad++; $display("FAIL rst_fs_clk got=%b exp=00", {frame_start, vga_clk}); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL first_fs_early got=%b exp=0", frame_start); end
        @(negedge clk);
        total += 2;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL first_fs got=%b exp=1", frame_start); end
        if (next_x !== 10'd1) begin bad++; $display("FAIL first_adv_x got=%0d exp=1", next_x); end
    endtask

    task automatic test_wrap();
        logic [48:0] obs, exp;
        int blank_cnt = 0, fs_cnt = 0;
        mode = 0;
        do_reset();
        while (kc < 2 * FRAME_CLKS / PD * PD / 2 + 4) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL wrap_model k=%0d got=%h exp=%h", kc, obs, exp); end
            if (kc == 2 * (VV * HT - 1)) begin
                total++;
                if ({next_x, next_y} !== {10'd799, 10'(VV - 1)}) begin bad++; $display("FAIL line_end got=%0d,%0d exp=799,%0d", next_x, next_y, VV - 1); end
            end
            if (kc == 2 * VV * HT) begin
                total++;
                if ({next_x, next_y} !== {10'd0, 10'(VV)}) begin bad++; $display("FAIL line_wrap got=%0d,%0d exp=0,%0d", next_x, next_y, VV); end
            end
            if (kc >= 2 * (VV * HT + 1) && kc < 2 * ((VV + 1) * HT + 1) && vga_blank_n) blank_cnt++;
            if (kc >= 3 && kc < FRAME_CLKS + 2 && frame_start) fs_cnt++;
            if (kc == FRAME_CLKS - 2) begin
                total++;
                if ({next_x, next_y} !== {10'd799, 10'(VT - 1)}) begin bad++; $display("FAIL frame_end got=%0d,%0d exp=799,%0d", next_x, next_y, VT - 1); end
            end
            if (kc == FRAME_CLKS) begin
                total++;
                if ({next_x, next_y} !== 20'd0) begin bad++; $display("FAIL frame_wrap got=%0d,%0d exp=0,0", next_x, next_y); end
            end
            if (kc == FRAME_CLKS + 2) begin
                total++;
                if (frame_start !== 1'b1) begin bad++; $display("FAIL wrap_fs got=%b exp=1", frame_start); end
            end
        end
        total += 2;
        if (blank_cnt != 0) begin bad++; $display("FAIL blank_line_vv got=%0d exp=0", blank_cnt); end
        if (fs_cnt != 0)    begin bad++; $display("FAIL fs_spurious got=%0d exp=0", fs_cnt); end
    endtask

    task automatic test_free_run();
        logic [48:0] obs, exp;
        logic   p_hs, p_vs;
        longint hs_fall = -1, vs_fall = -1, fs_last = -1;
        longint hs_per = 0, hs_low = 0, vs_per = 0, vs_low = 0, fs_gap = 0;
        longint stop_k;
        p_hs = vga_hs; p_vs = vga_vs;
        stop_k = kc + 2 * FRAME_CLKS;
        while (kc < stop_k) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL run_model k=%0d got=%h exp=%h", kc, obs, exp); end
            if (p_hs && !vga_hs) begin if (hs_fall >= 0) hs_per = kc - hs_fall; hs_fall = kc; end
            if (!p_hs && vga_hs && hs_fall >= 0) hs_low = kc - hs_fall;
            if (p_vs && !vga_vs) begin if (vs_fall >= 0) vs_per = kc - vs_fall; vs_fall = kc; end
            if (!p_vs && vga_vs && vs_fall >= 0) vs_low = kc - vs_fall;
            if (frame_start) begin if (fs_last >= 0) fs_gap = kc - fs_last; fs_last = kc; end
            p_hs = vga_hs; p_vs = vga_vs;
        end
        total += 5;
        if (hs_per != 1600)         begin bad++; $display("FAIL hs_period got=%0d exp=1600", hs_per); end
        if (hs_low != 192)          begin bad++; $display("FAIL hs_low got=%0d exp=192", hs_low); end
        if (vs_per != FRAME_CLKS)   begin bad++; $display("FAIL vs_period got=%0d exp=%0d", vs_per, FRAME_CLKS); end
        if (vs_low != VS * HT * PD) begin bad++; $display("FAIL vs_low got=%0d exp=%0d", vs_low, VS * HT * PD); end
        if (fs_gap != FRAME_CLKS)   begin bad++; $display("FAIL fs_spacing got=%0d exp=%0d", fs_gap, FRAME_CLKS); end
    endtask

    task automatic test_color_pulse();
        logic [48:0] obs, exp;
        longint kx = -1, kr = -1;
        int pulse_cnt = 0;
        mode = 1;
        do_reset();
        while (kc < 2 * HT * PD) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL pulse_model k=%0d got=%h exp=%h", kc, obs, exp); end
            if (kx < 0 && next_x == 10'd100) kx = kc;
            if (kr < 0 && vga_r == 8'hFF) kr = kc;
            if ({vga_r, vga_g, vga_b} == 24'hFF00FF) pulse_cnt++;
        end
        total += 2;
        if (kx < 0 || kr - kx != 2) begin bad++; $display("FAIL pulse_latency got=%0d exp=2", kr - kx); end
        if (pulse_cnt != 2 * PD)    begin bad++; $display("FAIL pulse_width got=%0d exp=%0d", pulse_cnt, 2 * PD); end
    endtask

    task automatic test_white();
        logic [48:0] obs, exp;
        int white = 0, leak = 0;
        mode = 2;
        do_reset();
        while (kc < FRAME_CLKS + 1) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL white_model k=%0d got=%h exp=%h", kc, obs, exp); end
            if (kc >= 2) begin
                if ({vga_r, vga_g, vga_b} == 24'hFFFFFF) white++;
                if (!vga_blank_n && {vga_r, vga_g, vga_b} != 24'h0) leak++;
            end
        end
        total += 2;
        if (white != 640 * VV * PD) begin bad++; $display("FAIL white_count got=%0d exp=%0d", white, 640 * VV * PD); end
        if (leak != 0)              begin bad++; $display("FAIL blank_leak got=%0d exp=0", leak); end
    endtask

    task automatic test_reset_mid();
        logic [48:0] obs, exp;
        mode = 0;
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        do_reset();
        while (kc < 2 * (2 * HT + 300)) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL mid_pre k=%0d got=%h exp=%h", kc, obs, exp); end
        end
        total++;
        if ({next_x, next_y} !== {10'd300, 10'd2}) begin bad++; $display("FAIL mid_pos got=%0d,%0d exp=300,2", next_x, next_y); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total += 2;
        if ({next_x, next_y} !== 20'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d,%0d exp=0,0", next_x, next_y); end
        if ({vga_hs, vga_vs, vga_blank_n} !== 3'b110) begin bad++; $display("FAIL mid_rst_sync got=%b exp=110", {vga_hs, vga_vs, vga_blank_n}); end
        while (kc < 2 * HT * PD) begin
            @(negedge clk);
            obs = snap(); exp = model_out(kc, mode); total++;
            if (obs !== exp) begin bad++; if (bad < 20) $display("FAIL mid_post k=%0d got=%h exp=%h", kc, obs, exp); end
        end
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        test_reset();
        test_wrap();
        test_free_run();
        test_color_pulse();
        test_white();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
